// File: rtl/controle_rodadas_memoria.sv
// controle_rodadas_memoria
//   Round sequencer for the memory game. Replays the stored sequence on the
//   LEDs, collects the player's moves, checks each one against the sequence
//   and reports win, loss or move timeout.
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-high
//   jogar         start/restart request (level)
//   nivel         0: 4 rounds, 1: 16 rounds (latched when a game starts)
//   jogada_feita  one-cycle pulse: a move is complete
//   igual         registered move matches the ROM word at endereco
//   endereco      sequence ROM address
//   leds_en       show the ROM word on the LEDs
//   registra      load the move register
//   pronto, ganhou, perdeu, timeout   end-of-game flags
//   db_rodada     current round (0-based)
//   db_estado     state code
//
// state        | code | meaning
// -------------+------+------------------------------------------------
// INICIAL      |  0   | idle, waiting for jogar
// PREPARA      |  1   | clear round/address, latch nivel
// MOSTRA       |  2   | show element endereco for T_MOSTRA cycles
// INTERVALO    |  3   | blank LEDs for T_INTERVALO cycles
// ESPERA       |  4   | wait for a move, at most T_TIMEOUT cycles
// REGISTRA     |  5   | load the move register
// COMPARA      |  6   | check the move
// PROX_RODADA  |  7   | advance to the next round
// FIM_ACERTO   |  A   | game won
// FIM_ERRO     |  B   | wrong move
// FIM_TIMEOUT  |  C   | no move in time
module controle_rodadas_memoria #(
    parameter int T_MOSTRA    = 500,
    parameter int T_INTERVALO = 250,
    parameter int T_TIMEOUT   = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       nivel,
    input  logic       jogada_feita,
    input  logic       igual,
    output logic [3:0] endereco,
    output logic       leds_en,
    output logic       registra,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_rodada,
    output logic [3:0] db_estado
);

    localparam int T_MAX_A = (T_MOSTRA > T_INTERVALO) ? T_MOSTRA : T_INTERVALO;
    localparam int T_MAX   = (T_MAX_A > T_TIMEOUT) ? T_MAX_A : T_TIMEOUT;
    localparam int TW      = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        INTERVALO   = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROX_RODADA = 4'h7,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hB,
        FIM_TIMEOUT = 4'hC
    } estado_t;

    estado_t        estado, estado_prox;
    logic [TW-1:0]  timer;
    logic [3:0]     rodada;
    logic           nivel_q;
    logic [3:0]     ultima;
    logic           fim_mostra, fim_intervalo, fim_espera;
    logic           em_tempo;
    logic           ultimo_elemento;

    assign ultima          = nivel_q ? 4'd15 : 4'd3;
    assign fim_mostra      = (timer == TW'(T_MOSTRA - 1));
    assign fim_intervalo   = (timer == TW'(T_INTERVALO - 1));
    assign fim_espera      = (timer == TW'(T_TIMEOUT - 1));
    assign em_tempo        = (estado == MOSTRA) || (estado == INTERVALO) || (estado == ESPERA);
    assign ultimo_elemento = (endereco == rodada);

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL:     if (jogar) estado_prox = PREPARA;
            PREPARA:     estado_prox = MOSTRA;
            MOSTRA:      if (fim_mostra) estado_prox = INTERVALO;
            INTERVALO:   if (fim_intervalo) estado_prox = ultimo_elemento ? ESPERA : MOSTRA;
            // a move on the last allowed cycle still counts
            ESPERA: begin
                if (jogada_feita)    estado_prox = REGISTRA;
                else if (fim_espera) estado_prox = FIM_TIMEOUT;
            end
            REGISTRA:    estado_prox = COMPARA;
            COMPARA: begin
                if (!igual)                 estado_prox = FIM_ERRO;
                else if (endereco < rodada) estado_prox = ESPERA;
                else if (rodada == ultima)  estado_prox = FIM_ACERTO;
                else                        estado_prox = PROX_RODADA;
            end
            PROX_RODADA: estado_prox = MOSTRA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                         if (jogar) estado_prox = PREPARA;
            default:     estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer    <= '0;
            rodada   <= 4'd0;
            endereco <= 4'd0;
            nivel_q  <= 1'b0;
        end else begin
            // restarting on every state change gives each timed state exactly T cycles
            if (!em_tempo || (estado_prox != estado)) timer <= '0;
            else                                      timer <= timer + 1'b1;

            case (estado)
                PREPARA: begin
                    rodada   <= 4'd0;
                    endereco <= 4'd0;
                    nivel_q  <= nivel;
                end
                INTERVALO: begin
                    if (fim_intervalo)
                        endereco <= ultimo_elemento ? 4'd0 : endereco + 4'd1;
                end
                COMPARA: begin
                    if (igual && (endereco < rodada)) endereco <= endereco + 4'd1;
                end
                PROX_RODADA: begin
                    rodada   <= rodada + 4'd1;
                    endereco <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign leds_en   = (estado == MOSTRA);
    assign registra  = (estado == REGISTRA);
    assign ganhou    = (estado == FIM_ACERTO);
    assign perdeu    = (estado == FIM_ERRO);
    assign timeout   = (estado == FIM_TIMEOUT);
    assign pronto    = ganhou || perdeu || timeout;
    assign db_rodada = rodada;
    assign db_estado = estado;

endmodule

// File: tb/tb_controle_rodadas_memoria.sv
module tb_controle_rodadas_memoria;

    localparam int TM = 4;
    localparam int TI = 2;
    localparam int TT = 20;

    localparam logic [5:0] S_NADA   = 6'b000000;
    localparam logic [5:0] S_LEDS   = 6'b100000;
    localparam logic [5:0] S_REG    = 6'b010000;
    localparam logic [5:0] S_ACERTO = 6'b001100;
    localparam logic [5:0] S_ERRO   = 6'b001010;
    localparam logic [5:0] S_TO     = 6'b001001;

    logic       clock = 1'b0;
    logic       reset, jogar, nivel, jogada_feita, igual;
    logic [3:0] endereco, db_rodada, db_estado;
    logic       leds_en, registra, pronto, ganhou, perdeu, timeout;

    int n_assert = 0;
    int n_fail   = 0;

    controle_rodadas_memoria #(.T_MOSTRA(TM), .T_INTERVALO(TI), .T_TIMEOUT(TT)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel),
        .jogada_feita(jogada_feita), .igual(igual), .endereco(endereco),
        .leds_en(leds_en), .registra(registra), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_rodada(db_rodada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] obs();
        return {db_estado, db_rodada, endereco, leds_en, registra, pronto, ganhou, perdeu, timeout};
    endfunction

    function automatic logic [17:0] esp(input int est, input int rod, input int ende, input logic [5:0] s);
        return {4'(est), 4'(rod), 4'(ende), s};
    endfunction

    task automatic verifica(input string tag, input logic [17:0] o, input logic [17:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (estado|rodada|endereco|leds,reg,pronto,ganhou,perdeu,timeout)", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ruido(input logic permite_jogar);
        jogada_feita = 1'($urandom_range(0, 1));
        igual        = 1'($urandom_range(0, 1));
        nivel        = 1'($urandom_range(0, 1));
        jogar        = permite_jogar & 1'($urandom_range(0, 1));
    endtask

    task automatic start_game(input logic nv);
        jogar = 1'b1; nivel = nv; jogada_feita = 1'b0;
        tick();
        verifica("prepara", {obs() & 18'h3C03F}, esp(1, 0, 0, S_NADA));
        jogar = 1'b0;
        tick();
    endtask

    // Round r shows elements 0..r, each TM cycles lit then TI cycles blank.
    task automatic show_round(input int r);
        for (int i = 0; i <= r; i++) begin
            for (int c = 0; c < TM; c++) begin
                verifica("mostra", obs(), esp(2, r, i, S_LEDS));
                ruido(1'b1);
                tick();
            end
            for (int c = 0; c < TI; c++) begin
                verifica("intervalo", obs(), esp(3, r, i, S_NADA));
                ruido(1'b1);
                tick();
            end
        end
        jogada_feita = 1'b0;
        verifica("espera_entrada", obs(), esp(4, r, 0, S_NADA));
    endtask

    task automatic make_move(input int r, input int m, input int w, input logic good,
                             input int ult, output logic fim, output logic [17:0] fin);
        fim = 1'b0;
        fin = '0;
        for (int k = 0; k < w; k++) begin
            verifica("espera", obs(), esp(4, r, m, S_NADA));
            ruido(1'b1);
            jogada_feita = 1'b0;
            tick();
        end
        verifica("espera", obs(), esp(4, r, m, S_NADA));
        jogada_feita = 1'b1;
        tick();
        verifica("registra", obs(), esp(5, r, m, S_REG));
        ruido(1'b1);
        tick();
        verifica("compara", obs(), esp(6, r, m, S_NADA));
        ruido(1'b0);
        igual = good;
        tick();
        jogada_feita = 1'b0;
        if (!good) begin
            fin = esp(4'hB, r, m, S_ERRO);
            verifica("fim_erro", obs(), fin);
            fim = 1'b1;
        end else if (m < r) begin
            verifica("proxima_jogada", obs(), esp(4, r, m + 1, S_NADA));
        end else if (r == ult) begin
            fin = esp(4'hA, r, m, S_ACERTO);
            verifica("fim_acerto", obs(), fin);
            fim = 1'b1;
        end else begin
            verifica("prox_rodada", obs(), esp(7, r, m, S_NADA));
            tick();
        end
    endtask

    task automatic timeout_seq(input int r, input int m, output logic [17:0] fin);
        for (int k = 0; k < TT; k++) begin
            verifica("espera_sem_jogada", obs(), esp(4, r, m, S_NADA));
            ruido(1'b0);
            jogada_feita = 1'b0;
            tick();
        end
        fin = esp(4'hC, r, m, S_TO);
        verifica("fim_timeout", obs(), fin);
    endtask

    // er/em: round and move answered wrong; tr/tm: round and move left to time out
    task automatic play_game(input logic nv, input int er, input int em, input int tr,
                             input int tm, output logic [17:0] fin);
        int   ult;
        int   w;
        logic fim;
        ult = nv ? 15 : 3;
        fin = '0;
        start_game(nv);
        for (int r = 0; r <= ult; r++) begin
            show_round(r);
            for (int m = 0; m <= r; m++) begin
                if (r == tr && m == tm) begin
                    timeout_seq(r, m, fin);
                    return;
                end
                w = (r == 1 && m == 0) ? TT - 1 : $urandom_range(0, 6);
                make_move(r, m, w, !(r == er && m == em), ult, fim, fin);
                if (fim) return;
            end
        end
    endtask

    task automatic hold_fim(input logic [17:0] fin, input int n);
        for (int k = 0; k < n; k++) begin
            verifica("fim_mantem", obs(), fin);
            ruido(1'b0);
            tick();
        end
        jogada_feita = 1'b0;
    endtask

    initial begin
        logic [17:0] fin;
        int          kind, er, em;

        reset = 1'b1; jogar = 1'b0; nivel = 1'b0; jogada_feita = 1'b0; igual = 1'b0;
        tick();
        verifica("reset", obs(), esp(0, 0, 0, S_NADA));
        reset = 1'b0;
        tick();
        verifica("inicial_parado", obs(), esp(0, 0, 0, S_NADA));

        play_game(1'b0, 99, 99, 99, 99, fin);
        verifica("vitoria_nivel0", obs(), esp(4'hA, 3, 3, S_ACERTO));
        hold_fim(fin, 5);

        play_game(1'b0, 2, 1, 99, 99, fin);
        verifica("erro_r2_m1", obs(), esp(4'hB, 2, 1, S_ERRO));
        hold_fim(fin, 5);

        play_game(1'b1, 99, 99, 99, 99, fin);
        verifica("vitoria_nivel1", obs(), esp(4'hA, 15, 15, S_ACERTO));
        hold_fim(fin, 3);

        play_game(1'b0, 99, 99, 1, 1, fin);
        verifica("timeout_r1_m1", obs(), esp(4'hC, 1, 1, S_TO));
        hold_fim(fin, 4);

        start_game(1'b0);
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        verifica("reset_meio_jogo", obs(), esp(0, 0, 0, S_NADA));
        reset = 1'b0;
        tick();
        verifica("reset_meio_jogo_inicial", obs(), esp(0, 0, 0, S_NADA));

        for (int g = 0; g < 4; g++) begin
            kind = $urandom_range(0, 2);
            er   = $urandom_range(0, 3);
            em   = $urandom_range(0, er);
            if (kind == 0)      play_game(1'b0, 99, 99, 99, 99, fin);
            else if (kind == 1) play_game(1'b0, er, em, 99, 99, fin);
            else                play_game(1'b0, 99, 99, er, em, fin);
            hold_fim(fin, 2);
        end

        reset = 1'b1;
        tick();
        verifica("reset_em_fim", obs(), esp(0, 0, 0, S_NADA));
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
